trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the width of the committed-trap counter.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 if_exc  input  1  fetch-stage instruction-address-misaligned request.
REQ-005 if_pc, if_tval  input  32 each  fetch-stage faulting PC and target address.
REQ-006 id_exc  input  1  decode-stage illegal-instruction request.
REQ-007 id_pc, id_tval  input  32 each  decode-stage faulting PC and instruction word.
REQ-008 mem_exc  input  1  memory-stage load/store-misaligned request.
REQ-009 mem_store  input  1  1 = store, 0 = load, for mem_exc.
REQ-010 mem_pc, mem_tval  input  32 each  memory-stage faulting PC and effective address.
REQ-011 mret_req  input  1  decode stage holds a valid MRET.
REQ-012 trap_vector_addr, mepc  input  32 each  current values read from the CSR file.
REQ-013 redirect_ack  input  1  PC register accepted the redirect this cycle.
REQ-014 e_raised  output  1  one-cycle commit strobe to the CSR file.
REQ-015 e_cause  output  4  mcause exception code.
REQ-016 e_pc, e_tval  output  32 each  values written into mepc and mtval.
REQ-017 is_mret  output  1  one-cycle MRET strobe to the CSR file.
REQ-018 flush  output  1  squash all in-flight instructions.
REQ-019 stall  output  1  freeze fetch and decode.
REQ-020 redirect_valid  output  1  redirect_pc is valid.
REQ-021 redirect_pc  output  32  new fetch address.
REQ-022 trap_count  output  CNT_W  number of committed exceptions.

Function
REQ-023 The FSM SHALL have states IDLE, COMMIT, MRET, REDIRECT.
REQ-024 In IDLE, if any *_exc input is high, the module SHALL select one request by priority mem > id > if (oldest stage first), latch its cause, PC and tval, and go to COMMIT.
REQ-025 Cause codes SHALL be: if = 0, id = 2, mem load = 4, mem store = 6.
REQ-026 In IDLE, if mret_req is high and no *_exc input is high, the FSM SHALL go to MRET.
REQ-027 A simultaneous exception and mret_req SHALL be resolved in favour of the exception; the MRET is discarded.
REQ-028 COMMIT SHALL last exactly one cycle, with e_raised = 1, flush = 1, e_cause/e_pc/e_tval = latched values, and trap_count incremented; then the FSM SHALL go to REDIRECT with redirect target trap_vector_addr, sampled in COMMIT.
REQ-029 MRET SHALL last exactly one cycle, with is_mret = 1 and flush = 1; then the FSM SHALL go to REDIRECT with redirect target mepc, sampled in MRET.
REQ-030 In REDIRECT, redirect_valid = 1, stall = 1 and flush = 1 SHALL hold, and redirect_pc SHALL stay constant until redirect_ack = 1; in the ack cycle the FSM SHALL return to IDLE.
REQ-031 redirect_valid SHALL remain asserted for each cycle redirect_ack is low.
REQ-032 An ack arriving in the first REDIRECT cycle SHALL cause a return to IDLE on the following edge.
REQ-033 stall SHALL be 1 in COMMIT, MRET and REDIRECT, and 0 in IDLE.
REQ-034 Exception and MRET requests arriving outside IDLE SHALL be ignored, not queued, because the pipeline is flushed.
REQ-035 redirect_ack SHALL be ignored outside REDIRECT.
REQ-036 e_raised and is_mret SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per request.
REQ-037 trap_count SHALL saturate at all-ones without wrapping.
REQ-038 trap_count SHALL NOT count MRET.
REQ-039 When e_raised = 0, e_cause/e_pc/e_tval SHALL hold their last latched values.
REQ-040 All outputs SHALL be registered or decoded from state only, with no combinational path from request inputs to outputs.

Reset
REQ-041 When rst = 1 at a clock edge, state SHALL become IDLE.
REQ-042 Reset SHALL clear e_raised, is_mret, flush, stall, redirect_valid, e_cause, e_pc, e_tval and trap_count to 0, and set redirect_pc = 32'h0001_0000.
REQ-043 Reset asserted in any state, including mid-REDIRECT, SHALL abandon the pending redirect with no strobe emitted.

Verification
REQ-044 Scenario: id_exc = 1, id_pc = 0x100, id_tval = 0xFFFFFFFF, trap_vector_addr = 0x200 -> next cycle e_raised = 1, e_cause = 2, e_pc = 0x100, e_tval = 0xFFFFFFFF; following cycle redirect_pc = 0x200.
REQ-045 Scenario: mem_exc (store, pc 0x40) and if_exc in the same cycle -> e_cause = 6, e_pc = 0x40; the if request is dropped; trap_count = 1.
REQ-046 Scenario: mret_req with mepc = 0x1234 -> one-cycle is_mret, then redirect_pc = 0x1234 held for 3 cycles while ack = 0, returning to IDLE after ack.
REQ-047 Scenario: mret_req and id_exc together -> only e_raised is pulsed, never is_mret.
REQ-048 Scenario: CNT_W = 2 with 5 traps -> trap_count = 3.
REQ-049 Scenario: rst pulsed during REDIRECT -> next cycle all outputs at reset values and no e_raised.

Source files
------------

// File: rtl/trap_ctrl.sv
// Exception/MRET commit controller: picks the oldest faulting stage, strobes the
// CSR file, then holds a redirect to the trap vector (or mepc) until the PC accepts it.
module trap_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_exc,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_tval,
  input  logic             id_exc,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_tval,
  input  logic             mem_exc,
  input  logic             mem_store,
  input  logic [31:0]      mem_pc,
  input  logic [31:0]      mem_tval,
  input  logic             mret_req,
  input  logic [31:0]      trap_vector_addr,
  input  logic [31:0]      mepc,
  input  logic             redirect_ack,
  output logic             e_raised,
  output logic [3:0]       e_cause,
  output logic [31:0]      e_pc,
  output logic [31:0]      e_tval,
  output logic             is_mret,
  output logic             flush,
  output logic             stall,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] trap_count
);

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    MRET,
    REDIRECT
  } state_t;

  state_t state, state_next;
  logic   any_exc;

  assign any_exc = if_exc | id_exc | mem_exc;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (any_exc)       state_next = COMMIT;
        else if (mret_req) state_next = MRET;
      end
      COMMIT:   state_next = REDIRECT;
      MRET:     state_next = REDIRECT;
      REDIRECT: if (redirect_ack) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Strobes and pipeline controls come purely from state, so no request input
  // can reach an output combinationally.
  always_comb begin
    e_raised       = 1'b0;
    is_mret        = 1'b0;
    flush          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    unique case (state)
      COMMIT: begin
        e_raised = 1'b1;
        flush    = 1'b1;
        stall    = 1'b1;
      end
      MRET: begin
        is_mret = 1'b1;
        flush   = 1'b1;
        stall   = 1'b1;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        stall          = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      e_cause     <= '0;
      e_pc        <= '0;
      e_tval      <= '0;
      trap_count  <= '0;
      redirect_pc <= 32'h0001_0000;
    end else begin
      state <= state_next;
      if (state == IDLE && any_exc) begin
        // Oldest stage wins; the counter is bumped as the trap enters COMMIT so
        // the new count is visible alongside e_raised.
        if (mem_exc) begin
          e_cause <= mem_store ? 4'd6 : 4'd4;
          e_pc    <= mem_pc;
          e_tval  <= mem_tval;
        end else if (id_exc) begin
          e_cause <= 4'd2;
          e_pc    <= id_pc;
          e_tval  <= id_tval;
        end else begin
          e_cause <= 4'd0;
          e_pc    <= if_pc;
          e_tval  <= if_tval;
        end
        if (trap_count != '1) trap_count <= trap_count + 1'b1;
      end
      if (state == COMMIT) redirect_pc <= trap_vector_addr;
      if (state == MRET)   redirect_pc <= mepc;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: transaction-level reference model driven by directed
// scenarios and random request mixes, with a CNT_W=2 copy for saturation.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_exc, id_exc, mem_exc, mem_store, mret_req, redirect_ack;
  logic [31:0] if_pc, if_tval, id_pc, id_tval, mem_pc, mem_tval;
  logic [31:0] trap_vector_addr, mepc;

  logic        e_raised, is_mret, flush, stall, redirect_valid;
  logic [3:0]  e_cause;
  logic [31:0] e_pc, e_tval, redirect_pc;
  logic [15:0] trap_count;

  logic        e_raised2, is_mret2, flush2, stall2, redirect_valid2;
  logic [3:0]  e_cause2;
  logic [31:0] e_pc2, e_tval2, redirect_pc2;
  logic [1:0]  trap_count2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned m_count;
  logic [3:0]  m_cause;
  logic [31:0] m_pc, m_tval;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk(clk), .rst(rst),
    .if_exc(if_exc), .if_pc(if_pc), .if_tval(if_tval),
    .id_exc(id_exc), .id_pc(id_pc), .id_tval(id_tval),
    .mem_exc(mem_exc), .mem_store(mem_store), .mem_pc(mem_pc), .mem_tval(mem_tval),
    .mret_req(mret_req), .trap_vector_addr(trap_vector_addr), .mepc(mepc),
    .redirect_ack(redirect_ack),
    .e_raised(e_raised), .e_cause(e_cause), .e_pc(e_pc), .e_tval(e_tval),
    .is_mret(is_mret), .flush(flush), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_count(trap_count)
  );

  trap_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .if_exc(if_exc), .if_pc(if_pc), .if_tval(if_tval),
    .id_exc(id_exc), .id_pc(id_pc), .id_tval(id_tval),
    .mem_exc(mem_exc), .mem_store(mem_store), .mem_pc(mem_pc), .mem_tval(mem_tval),
    .mret_req(mret_req), .trap_vector_addr(trap_vector_addr), .mepc(mepc),
    .redirect_ack(redirect_ack),
    .e_raised(e_raised2), .e_cause(e_cause2), .e_pc(e_pc2), .e_tval(e_tval2),
    .is_mret(is_mret2), .flush(flush2), .stall(stall2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .trap_count(trap_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sat_count(input int unsigned n, input int unsigned max);
    return (n > max) ? max : n;
  endfunction

  // Random request traffic; used where the controller must ignore it.
  task automatic drive_noise(input bit keep_addr);
    if_exc    = 1'($urandom_range(0, 1));
    id_exc    = 1'($urandom_range(0, 1));
    mem_exc   = 1'($urandom_range(0, 1));
    mem_store = 1'($urandom_range(0, 1));
    mret_req  = 1'($urandom_range(0, 1));
    if_pc  = $urandom; if_tval  = $urandom;
    id_pc  = $urandom; id_tval  = $urandom;
    mem_pc = $urandom; mem_tval = $urandom;
    redirect_ack = 1'($urandom_range(0, 1));
    if (!keep_addr) begin
      trap_vector_addr = $urandom;
      mepc             = $urandom;
    end
  endtask

  task automatic clear_reqs();
    if_exc = 1'b0; id_exc = 1'b0; mem_exc = 1'b0; mret_req = 1'b0; mem_store = 1'b0;
    redirect_ack = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, ".cnt"},  32'(trap_count),  sat_count(m_count, 32'hFFFF));
    check({tag, ".cnt2"}, 32'(trap_count2), sat_count(m_count, 3));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".e_raised"}, 32'(e_raised), 0);
    check({tag, ".is_mret"},  32'(is_mret), 0);
    check({tag, ".flush"},    32'(flush), 0);
    check({tag, ".stall"},    32'(stall), 0);
    check({tag, ".rvalid"},   32'(redirect_valid), 0);
    check({tag, ".cause"},    32'(e_cause), 32'(m_cause));
    check({tag, ".epc"},      e_pc, m_pc);
    check({tag, ".etval"},    e_tval, m_tval);
    check_counts(tag);
  endtask

  task automatic check_reset(input string tag);
    check_idle(tag);
    check({tag, ".rpc"}, redirect_pc, 32'h0001_0000);
  endtask

  // Inputs currently driven form one request cycle; the model decides the outcome.
  task automatic run_txn(input string tag, input int unsigned delay, input bit rst_mid,
                         input bit keep_addr);
    bit          exc, mr;
    logic [31:0] target;
    exc = if_exc | id_exc | mem_exc;
    mr  = mret_req;
    if (mem_exc) begin
      m_cause = mem_store ? 4'd6 : 4'd4; m_pc = mem_pc; m_tval = mem_tval;
    end else if (id_exc) begin
      m_cause = 4'd2; m_pc = id_pc; m_tval = id_tval;
    end else if (if_exc) begin
      m_cause = 4'd0; m_pc = if_pc; m_tval = if_tval;
    end
    if (exc) m_count++;
    step();
    if (!exc && !mr) begin
      check_idle({tag, ".none"});
      return;
    end
    check({tag, ".e_raised"}, 32'(e_raised), 32'(exc));
    check({tag, ".is_mret"},  32'(is_mret), 32'(!exc));
    check({tag, ".flush"},    32'(flush), 1);
    check({tag, ".stall"},    32'(stall), 1);
    check({tag, ".rvalid0"},  32'(redirect_valid), 0);
    check({tag, ".cause"},    32'(e_cause), 32'(m_cause));
    check({tag, ".epc"},      e_pc, m_pc);
    check({tag, ".etval"},    e_tval, m_tval);
    check_counts(tag);
    drive_noise(keep_addr);
    target = exc ? trap_vector_addr : mepc;
    step();
    for (int unsigned k = 0; k <= delay; k++) begin
      check({tag, ".rvalid"},  32'(redirect_valid), 1);
      check({tag, ".rstall"},  32'(stall), 1);
      check({tag, ".rflush"},  32'(flush), 1);
      check({tag, ".rpc"},     redirect_pc, target);
      check({tag, ".rstrobe"}, 32'({e_raised, is_mret}), 0);
      if (rst_mid) begin
        drive_noise(1'b0);
        rst = 1'b1;
        step();
        m_count = 0; m_cause = '0; m_pc = '0; m_tval = '0;
        check_reset({tag, ".rst"});
        rst = 1'b0;
        clear_reqs();
        return;
      end
      drive_noise(1'b0);
      redirect_ack = (k == delay);
      step();
    end
    check({tag, ".back_rvalid"}, 32'(redirect_valid), 0);
    check({tag, ".back_stall"},  32'(stall), 0);
    check({tag, ".back_flush"},  32'(flush), 0);
    clear_reqs();
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    if_pc = '0; if_tval = '0; id_pc = '0; id_tval = '0; mem_pc = '0; mem_tval = '0;
    trap_vector_addr = '0; mepc = '0;
    m_count = 0; m_cause = '0; m_pc = '0; m_tval = '0;
    step();
    step();
    check_reset("reset");
    rst = 1'b0;

    // Illegal instruction from decode.
    id_exc = 1'b1; id_pc = 32'h100; id_tval = 32'hFFFF_FFFF; trap_vector_addr = 32'h200;
    run_txn("id_exc", 1, 1'b0, 1'b1);

    // Store misalign beats fetch misalign.
    mem_exc = 1'b1; mem_store = 1'b1; mem_pc = 32'h40; mem_tval = 32'h43;
    if_exc = 1'b1; if_pc = 32'h80; if_tval = 32'h82;
    run_txn("mem_vs_if", 0, 1'b0, 1'b1);

    // MRET with the redirect held for three unacked cycles.
    mret_req = 1'b1; mepc = 32'h1234;
    run_txn("mret", 3, 1'b0, 1'b1);

    // Exception wins over a simultaneous MRET.
    mret_req = 1'b1; id_exc = 1'b1; id_pc = 32'h300; id_tval = 32'h0000_0013;
    trap_vector_addr = 32'h200;
    run_txn("mret_vs_id", 0, 1'b0, 1'b1);

    // Reset abandons a pending redirect.
    if_exc = 1'b1; if_pc = 32'h500; if_tval = 32'h502;
    run_txn("rst_redir", 2, 1'b1, 1'b0);

    for (int unsigned i = 0; i < 150; i++) begin
      if_exc    = ($urandom_range(0, 3) == 0);
      id_exc    = ($urandom_range(0, 3) == 0);
      mem_exc   = ($urandom_range(0, 3) == 0);
      mem_store = 1'($urandom_range(0, 1));
      mret_req  = ($urandom_range(0, 2) == 0);
      if_pc  = $urandom; if_tval  = $urandom;
      id_pc  = $urandom; id_tval  = $urandom;
      mem_pc = $urandom; mem_tval = $urandom;
      trap_vector_addr = $urandom; mepc = $urandom;
      redirect_ack = 1'($urandom_range(0, 1));
      run_txn("rand", $urandom_range(0, 4), ($urandom_range(0, 29) == 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
